// File: rtl/guess_tracker.sv
// Guess-tracking game controller: latches a target board and a miss budget on start,
// then classifies one guess per cycle as hit, duplicate, out-of-range or miss.
module guess_tracker #(
  parameter int unsigned N_CELLS = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_CELLS-1:0] board,
  input  logic [CNT_W-1:0]   guess_budget,
  input  logic               guess_valid,
  input  logic [IDX_W-1:0]   guess_idx,
  output logic               guess_ready,
  output logic               result_valid,
  output logic               result_hit,
  output logic               result_dup,
  output logic               result_err,
  output logic [N_CELLS-1:0] found_mask,
  output logic [CNT_W-1:0]   remaining,
  output logic               win,
  output logic               lose
);

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_e;

  state_e             state_q;
  logic [N_CELLS-1:0] board_q;
  logic [N_CELLS-1:0] found_q;
  logic [CNT_W-1:0]   rem_q;
  logic               ready_q, win_q, lose_q;
  logic               rv_q, hit_q, dup_q, err_q;

  logic               idx_ok_c;
  logic [N_CELLS-1:0] idx_bit_c;
  logic               cell_lit_c, cell_found_c, accept_c;
  logic [N_CELLS-1:0] found_hit_c;
  state_e             start_state_c;

  // One-hot of the guessed cell; all-zero when the index is off the board.
  always_comb begin
    idx_ok_c      = 32'(guess_idx) < N_CELLS;
    idx_bit_c     = idx_ok_c ? (N_CELLS'(1) << guess_idx) : '0;
    cell_lit_c    = |(board_q & idx_bit_c);
    cell_found_c  = |(found_q & idx_bit_c);
    found_hit_c   = found_q | idx_bit_c;
    accept_c      = guess_valid && (state_q == PLAY);
    start_state_c = (board == '0)        ? WIN  :
                    (guess_budget == '0) ? LOSE : PLAY;
  end

  // Registered {guess_ready, win, lose} for the state being entered.
  function automatic logic [2:0] flags_of(input state_e s);
    return {s == PLAY, s == WIN, s == LOSE};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      board_q <= '0;
      found_q <= '0;
      rem_q   <= '0;
      {ready_q, win_q, lose_q} <= 3'b000;
      {rv_q, hit_q, dup_q, err_q} <= 4'b0000;
    end else begin
      {rv_q, hit_q, dup_q, err_q} <= 4'b0000;
      if (start) begin
        board_q <= board;
        found_q <= '0;
        rem_q   <= guess_budget;
        state_q <= start_state_c;
        {ready_q, win_q, lose_q} <= flags_of(start_state_c);
      end else if (accept_c) begin
        rv_q <= 1'b1;
        if (!idx_ok_c) begin
          err_q <= 1'b1;
        end else if (cell_lit_c && cell_found_c) begin
          dup_q <= 1'b1;
        end else if (cell_lit_c) begin
          hit_q   <= 1'b1;
          found_q <= found_hit_c;
          if (found_hit_c == board_q) begin
            state_q <= WIN;
            {ready_q, win_q, lose_q} <= flags_of(WIN);
          end
        end else begin
          if (rem_q != '0) rem_q <= rem_q - CNT_W'(1);
          if (rem_q <= CNT_W'(1)) begin
            state_q <= LOSE;
            {ready_q, win_q, lose_q} <= flags_of(LOSE);
          end
        end
      end
    end
  end

  assign guess_ready  = ready_q;
  assign result_valid = rv_q;
  assign result_hit   = hit_q;
  assign result_dup   = dup_q;
  assign result_err   = err_q;
  assign found_mask   = found_q;
  assign remaining    = rem_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule

// File: tb/tb_guess_tracker.sv
// Scoreboard bench for guess_tracker: directed rounds plus random traffic against a
// set-based game model, and a 12-cell instance for out-of-range indices.
module tb_guess_tracker;

  localparam int unsigned N = 16;
  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_WIN = 2, PH_LOSE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, start = 1'b0, guess_valid = 1'b0;
  logic [N-1:0]  board = '0;
  logic [3:0]    guess_budget = '0, guess_idx = '0;
  logic          guess_ready, result_valid, result_hit, result_dup, result_err, win, lose;
  logic [N-1:0]  found_mask;
  logic [3:0]    remaining;

  guess_tracker #(.N_CELLS(16), .IDX_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .board(board), .guess_budget(guess_budget),
    .guess_valid(guess_valid), .guess_idx(guess_idx), .guess_ready(guess_ready),
    .result_valid(result_valid), .result_hit(result_hit), .result_dup(result_dup),
    .result_err(result_err), .found_mask(found_mask), .remaining(remaining),
    .win(win), .lose(lose));

  logic        r12 = 1'b1, s12 = 1'b0, gv12 = 1'b0;
  logic [11:0] b12 = '0;
  logic [3:0]  bud12 = '0, gi12 = '0;
  logic        o12_ready, o12_rv, o12_hit, o12_dup, o12_err, o12_win, o12_lose;
  logic [11:0] o12_found;
  logic [3:0]  o12_rem;

  guess_tracker #(.N_CELLS(12), .IDX_W(4), .CNT_W(4)) dut12 (
    .clk(clk), .reset(r12), .start(s12), .board(b12), .guess_budget(bud12),
    .guess_valid(gv12), .guess_idx(gi12), .guess_ready(o12_ready),
    .result_valid(o12_rv), .result_hit(o12_hit), .result_dup(o12_dup),
    .result_err(o12_err), .found_mask(o12_found), .remaining(o12_rem),
    .win(o12_win), .lose(o12_lose));

  typedef struct {
    logic ready, win, lose, rv, hit, dup, err;
    logic [N-1:0] found;
    logic [3:0] rem;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;

  // Game model: board and found cells as sets, misses as a plain integer count.
  int phase = PH_IDLE;
  logic [N-1:0] m_board = '0, m_found = '0;
  int m_rem = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [N-1:0] b, input int bud,
                     input logic gv, input int gi);
    exp_t e;
    @(negedge clk);
    reset = r; start = s; board = b; guess_budget = 4'(bud);
    guess_valid = gv; guess_idx = 4'(gi);
    e.rv = 0; e.hit = 0; e.dup = 0; e.err = 0;
    if (r) begin
      phase = PH_IDLE; m_board = '0; m_found = '0; m_rem = 0;
    end else if (s) begin
      m_board = b; m_found = '0; m_rem = bud;
      phase = (b == 0) ? PH_WIN : (bud == 0) ? PH_LOSE : PH_PLAY;
    end else if (phase == PH_PLAY && gv) begin
      e.rv = 1;
      if (gi >= int'(N)) e.err = 1;
      else if (m_board[gi] && m_found[gi]) e.dup = 1;
      else if (m_board[gi]) begin
        e.hit = 1;
        m_found[gi] = 1'b1;
        if ($countones(m_found) == $countones(m_board)) phase = PH_WIN;
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) phase = PH_LOSE;
      end
    end
    e.ready = (phase == PH_PLAY);
    e.win   = (phase == PH_WIN);
    e.lose  = (phase == PH_LOSE);
    e.found = m_found;
    e.rem   = 4'(m_rem);
    q.push_back(e);
  endtask

  // Monitor: compares what the DUT presents after each edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result_valid", 32'(result_valid), 32'(e.rv));
        chk("result_hit",   32'(result_hit),   32'(e.hit));
        chk("result_dup",   32'(result_dup),   32'(e.dup));
        chk("result_err",   32'(result_err),   32'(e.err));
        chk("guess_ready",  32'(guess_ready),  32'(e.ready));
        chk("win",          32'(win),          32'(e.win));
        chk("lose",         32'(lose),         32'(e.lose));
        chk("found_mask",   32'(found_mask),   32'(e.found));
        chk("remaining",    32'(remaining),    32'(e.rem));
      end
    end
  end

  initial begin
    logic [N-1:0] rb;
    // 12-cell instance: indices 12..15 are off the board.
    @(negedge clk); r12 = 1'b0; s12 = 1'b1; b12 = 12'h810; bud12 = 4'd3;
    @(negedge clk); s12 = 1'b0; gv12 = 1'b1; gi12 = 4'd13;
    @(negedge clk);
    chk("n12_err13_rv", 32'(o12_rv), 32'd1);
    chk("n12_err13", 32'(o12_err), 32'd1);
    chk("n12_err13_rem", 32'(o12_rem), 32'd3);
    chk("n12_err13_found", 32'(o12_found), 32'h0);
    gi12 = 4'd11;
    @(negedge clk);
    chk("n12_hit11", 32'(o12_hit), 32'd1);
    chk("n12_hit11_err", 32'(o12_err), 32'd0);
    chk("n12_hit11_found", 32'(o12_found), 32'h800);
    gi12 = 4'd12;
    @(negedge clk);
    chk("n12_err12", 32'(o12_err), 32'd1);
    chk("n12_err12_rem", 32'(o12_rem), 32'd3);
    chk("n12_err12_found", 32'(o12_found), 32'h800);
    chk("n12_ready", 32'(o12_ready), 32'd1);
    gv12 = 1'b0;
    @(negedge clk);
    chk("n12_idle_rv", 32'(o12_rv), 32'd0);

    // Directed rounds on the 16-cell instance.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 3);
    cyc(0, 0, 0, 0, 1, 3);                    // guess in IDLE ignored
    cyc(0, 1, 16'h0011, 3, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 4);                    // second hit wins
    cyc(0, 0, 0, 0, 1, 7);                    // ignored in WIN
    cyc(0, 1, 16'h0001, 2, 0, 0);
    cyc(0, 0, 0, 0, 1, 5);
    cyc(0, 0, 0, 0, 1, 6);                    // last miss loses
    cyc(0, 0, 0, 0, 1, 0);                    // ignored in LOSE
    cyc(0, 1, 16'h0003, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);                    // dup
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 16'h0000, 5, 0, 0);             // empty board wins at once
    cyc(0, 1, 16'h00F0, 0, 0, 0);             // zero budget loses at once
    cyc(0, 1, 16'h00F0, 4, 0, 0);
    cyc(0, 0, 0, 0, 1, 4);
    cyc(1, 0, 0, 0, 1, 5);                    // reset beats guess
    cyc(0, 1, 16'h00F0, 4, 0, 0);
    cyc(0, 0, 0, 0, 1, 4);
    cyc(0, 1, 16'h0F00, 6, 1, 5);             // start beats guess
    cyc(0, 0, 16'hFFFF, 1, 1, 9);             // board/budget ignored after start

    for (int i = 0; i < 3000; i++) begin
      rb = N'($urandom & $urandom);
      if ($urandom_range(0, 9) == 0) rb = '0;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, rb,
          int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
          int'($urandom_range(0, 15)));
    end
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/guess_tracker.md
GUESS_TRACKER -- requirements
Module: guess_tracker

Interface
REQ-001 Parameter N_CELLS, default 16: number of board cells, 2..256.
REQ-002 Parameter IDX_W, default 4: guess index width, ceil(log2(N_CELLS)), minimum 1.
REQ-003 Parameter CNT_W, default 4: guess budget and counter width, 1..8.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a round; latches board and budget.
REQ-007 board  input  N_CELLS  target pattern; bit i set means cell i is lit.
REQ-008 guess_budget  input  CNT_W  number of misses allowed in the round.
REQ-009 guess_valid  input  1  guess offered this cycle.
REQ-010 guess_idx  input  IDX_W  cell index being guessed.
REQ-011 guess_ready  output  1  high only in PLAY; a guess is accepted when guess_valid and guess_ready are both high.
REQ-012 result_valid  output  1  one-cycle pulse reporting the previous accepted guess.
REQ-013 result_hit, result_dup, result_err  output  1 each  classification flags, valid only with result_valid.
REQ-014 found_mask  output  N_CELLS  cells correctly found this round.
REQ-015 remaining  output  CNT_W  misses still allowed.
REQ-016 win, lose  output  1 each  high while in WIN or LOSE respectively.

Function
REQ-017 FSM states: IDLE, PLAY, WIN, LOSE; all outputs registered.
REQ-018 start in any state, at edge t: latch board to board_q and guess_budget to remaining, clear found_mask; state at t+1 is PLAY, or WIN if board is 0, else LOSE if guess_budget is 0 (WIN takes priority).
REQ-019 start takes priority over a guess accepted in the same cycle; that guess is dropped with no result_valid.
REQ-020 Changes on board or guess_budget after start have no effect until the next start.
REQ-021 Accepted guess, classified at the same edge, with result_valid and flags high the following cycle:
- guess_idx >= N_CELLS: result_err=1; no state change.
- board_q[idx]=1 and found_mask[idx]=1: result_dup=1; no state change.
- board_q[idx]=1 and found_mask[idx]=0: result_hit=1; found_mask[idx] set.
- otherwise (miss): all flags 0; remaining decremented by 1.
REQ-022 Exactly one flag or none is high per result_valid.
REQ-023 Win check: after a hit, if the updated found_mask equals board_q, the state becomes WIN at the same edge, so win and result_valid rise together.
REQ-024 Lose check: a miss with remaining=1 sets remaining to 0 and the state becomes LOSE at the same edge.
REQ-025 remaining never wraps below 0; it is never decremented outside PLAY.
REQ-026 guess_valid is ignored in IDLE, WIN and LOSE: no result_valid pulse and no state change.
REQ-027 Back-to-back guesses are accepted every cycle in PLAY; throughput is 1 guess per clk and latency is 1 cycle.
REQ-028 found_mask and remaining hold their values in WIN and LOSE until the next start or reset.

Reset
REQ-029 reset at an edge forces: state IDLE; found_mask, board_q and remaining to 0; guess_ready, result_valid, all flags, win and lose to 0.
REQ-030 reset overrides start and guess_valid in the same cycle; reset mid-round abandons the round with no result pulse.

Verification
REQ-031 N_CELLS=16. start with board=0x0011 and budget=3; guess 0 then 4 -> hit, hit; found_mask=0x0011 and win=1 in the same cycle as the second result_valid; remaining=3.
REQ-032 board=0x0001, budget=2; guess 5, then 6 -> two misses; remaining goes 1 then 0; lose=1 with the second result; a further guess_valid gives no result_valid.
REQ-033 board=0x0003, budget=1; guess 0, 0, 1 -> hit, dup, hit; remaining stays 1; win=1.
REQ-034 N_CELLS=12, IDX_W=4: guess 13 -> result_err=1; remaining and found_mask unchanged.
REQ-035 start with board=0 -> WIN next cycle; start with budget=0 and board≠0 -> LOSE next cycle.
REQ-036 In PLAY with found_mask≠0: reset and guess_valid asserted together -> IDLE, all outputs 0, no result_valid; start and guess together -> new round with found_mask=0 and no result_valid.
